keypad_scan_fsm: RTL
====================

Name: keypad_scan_fsm

Overview:
- Drives the rows of a 4x4 keypad and samples its columns. Synchronizes and debounces each key press.
- Maintains a two-deep history of the most recent debounced keys.
- Sits directly upstream of the key-to-digit converters and the 7-segment display path. Its two key outputs feed those converters.
- Runs on the divided 24 MHz system clock.

Parameters:
- SCAN_CYCLES, 24000: clock cycles each row is driven before its columns are sampled (1 ms at 24 MHz).
- DEBOUNCE_CYCLES, 480000: consecutive stable cycles required to accept a press or a release (20 ms).
- REPEAT_CYCLES, 12000000: auto-repeat period. Used only when KEYPAD_REPEAT_EN is defined.

Ports:
- clk  input  1  system clock (24 MHz divided oscillator).
- reset  input  1  asynchronous, active-high reset.
- keypad_column  input  4  raw column inputs, active-low (pulled up), asynchronous to clk.
- keypad_row  output  4  row drive, active-low, one-cold.
- most_recent_key  output  8  {row one-hot[7:4], column one-hot[3:0]} of the last accepted key. 8'h00 = none.
- second_most_recent_key  output  8  previous value of most_recent_key.
- key_pressed  output  1  one-cycle pulse when a key is accepted.

Behaviour:
- Reset values (asynchronous, active-high, applied immediately mid-operation):
  - keypad_row = 4'b1110; both key outputs = 8'h00; key_pressed = 0.
  - State = SCAN; all counters = 0; synchronizer flops = 4'b1111.
- Synchronizer: keypad_column passes through a 2-flop synchronizer; col_s is its output. All decisions use col_s only.
- Counter width is $clog2(max parameter + 1). Every counter clears on each state transition.
- SCAN:
  - Row rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, dwelling SCAN_CYCLES cycles per row.
  - col_s is sampled only on the final dwell cycle.
  - Exactly one bit of col_s low: latch candidate = {~keypad_row, ~col_s}, hold the row, go to PRESS_DEBOUNCE.
  - Zero bits low, or more than one bit low (ambiguous/ghost): advance to the next row, no capture.
- PRESS_DEBOUNCE:
  - Row held. Counts cycles while col_s equals ~candidate[3:0].
  - Any mismatch: return to SCAN, advance to the next row, no output change.
  - Count reaches DEBOUNCE_CYCLES-1: on the next edge, second_most_recent_key <= most_recent_key, most_recent_key <= candidate, key_pressed = 1 for exactly one cycle. Go to HELD.
- HELD:
  - Row held. Other keys are ignored (single-key lockout).
  - Stays while any col_s bit is low, even if the low pattern changes.
  - col_s == 4'b1111: go to RELEASE_DEBOUNCE.
- RELEASE_DEBOUNCE:
  - Counts cycles with col_s == 4'b1111.
  - Any low bit: back to HELD.
  - Count reaches DEBOUNCE_CYCLES-1: go to SCAN and advance to the next row.
- Latency:
  - Accepted press: key_pressed asserts SCAN_CYCLES + DEBOUNCE_CYCLES + 2 sync cycles (worst case plus up to 3 row dwells) after a stable press begins.
  - Outputs are registered; no combinational path from keypad_column to any output.
- Repeated identical key: both history slots may hold the same code. This is legal.
- Key outputs change only on an accept edge, so the display never sees a transient code.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter runs from HELD entry. Every REPEAT_CYCLES cycles the same history shift and key_pressed pulse occur again with the held candidate. The counter clears on leaving HELD.
- Undefined: exactly one accept per physical press; REPEAT_CYCLES is unused and no repeat counter is synthesized.

Test Plan:
All tests use SCAN_CYCLES=4, DEBOUNCE_CYCLES=16, REPEAT_CYCLES=64.
- Reset: assert reset for 3 cycles -> keypad_row=4'b1110, keys=8'h00, key_pressed=0. Rows then rotate every 4 cycles.
- Clean press: model a key at row1/col2 (col[2] low whenever row[1] low) for 60 cycles -> exactly one key_pressed pulse; most_recent_key=8'b0010_0100; second_most_recent_key=8'h00.
- Bounce: same key low for 6 cycles, then released -> no pulse, keys unchanged, scanning resumes at the next row.
- History: press row0/col0, release 40 cycles, then press row3/col3 -> second=8'b0001_0001, most=8'b1000_1000. Two pulses total.
- Ghost/reset: two columns low on one row -> no capture. Then assert reset mid-PRESS_DEBOUNCE -> outputs return to reset values in the same cycle, with no pulse.
- Repeat (KEYPAD_REPEAT_EN defined): hold row2/col1 for 200 cycles -> initial pulse plus one pulse every 64 cycles while held. Undefined -> a single pulse.

Source files
------------

// File: rtl/keypad_scan_fsm.sv
// 4x4 keypad scanner: rotates one-cold row drive, synchronizes and debounces columns, keeps a two-deep key history.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_fsm #(
  parameter int unsigned SCAN_CYCLES     = 24000,
  parameter int unsigned DEBOUNCE_CYCLES = 480000,
  parameter int unsigned REPEAT_CYCLES   = 12000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_column,
  output logic [3:0] keypad_row,
  output logic [7:0] most_recent_key,
  output logic [7:0] second_most_recent_key,
  output logic       key_pressed
);

  localparam int unsigned MAX_SD  = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_SD > REPEAT_CYCLES) ? MAX_SD : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DEBOUNCE,
    HELD,
    RELEASE_DEBOUNCE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         row_q, row_d;
  logic [7:0]         cand_q, cand_d;
  logic [7:0]         most_q, most_d;
  logic [7:0]         second_q, second_d;
  logic               pulse_q, pulse_d;
  logic [3:0]         sync1_q, col_s_q;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0]   rpt_q, rpt_d;
`endif

  logic [3:0] row_next;
  assign row_next = {row_q[2:0], row_q[3]};

  // State, counters, history and the two-flop column synchronizer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SCAN;
      cnt_q    <= '0;
      row_q    <= 4'b1110;
      cand_q   <= 8'h00;
      most_q   <= 8'h00;
      second_q <= 8'h00;
      pulse_q  <= 1'b0;
      sync1_q  <= 4'b1111;
      col_s_q  <= 4'b1111;
`ifdef KEYPAD_REPEAT_EN
      rpt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      cand_q   <= cand_d;
      most_q   <= most_d;
      second_q <= second_d;
      pulse_q  <= pulse_d;
      sync1_q  <= keypad_column;
      col_s_q  <= sync1_q;
`ifdef KEYPAD_REPEAT_EN
      rpt_q    <= rpt_d;
`endif
    end
  end

  // Next-state logic; every state change clears the dwell/debounce counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    row_d    = row_q;
    cand_d   = cand_q;
    most_d   = most_q;
    second_d = second_q;
    pulse_d  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d    = '0;
`endif

    unique case (state_q)
      SCAN: begin
        if (cnt_q == CNT_W'(SCAN_CYCLES - 1)) begin
          cnt_d = '0;
          if ($onehot(~col_s_q)) begin
            cand_d  = {~row_q, ~col_s_q};
            state_d = PRESS_DEBOUNCE;
          end else begin
            row_d = row_next;
          end
        end
      end

      PRESS_DEBOUNCE: begin
        if (col_s_q != ~cand_q[3:0]) begin
          cnt_d   = '0;
          row_d   = row_next;
          state_d = SCAN;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d    = '0;
          second_d = most_q;
          most_d   = cand_q;
          pulse_d  = 1'b1;
          state_d  = HELD;
        end
      end

      HELD: begin
        cnt_d = '0;
        if (col_s_q == 4'b1111) begin
          state_d = RELEASE_DEBOUNCE;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rpt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
          second_d = most_q;
          most_d   = cand_q;
          pulse_d  = 1'b1;
        end else begin
          rpt_d = rpt_q + CNT_W'(1);
        end
`endif
      end

      RELEASE_DEBOUNCE: begin
        if (col_s_q != 4'b1111) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt_d   = '0;
          row_d   = row_next;
          state_d = SCAN;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
  end

  assign keypad_row             = row_q;
  assign most_recent_key        = most_q;
  assign second_most_recent_key = second_q;
  assign key_pressed            = pulse_q;

endmodule
